// File: rtl/meter_display_driver_if.sv
// Meter-controller to display-driver bus.
// The controller side drives time and status. The driver side returns the
// display lines and the latched BCD value.
interface meter_display_driver_if;
    logic [15:0] curr_time;
    logic        below200;
    logic        isZero;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd;

    modport master (
        output curr_time, below200, isZero,
        input  an, seg, dp, bcd
    );

    modport slave (
        input  curr_time, below200, isZero,
        output an, seg, dp, bcd
    );
endinterface

// File: rtl/meter_display_driver.sv
// Parking-meter display driver.
// The block converts the remaining time to 4-digit BCD with a sequential
// double-dabble FSM. It scans the digits onto a common-anode 7-segment
// display and applies the meter blink policy.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
// The ones digit is never blanked.
module meter_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    meter_display_driver_if.slave bus
);

    localparam int unsigned RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned TIME_W   = 16;
    localparam int unsigned ITER_W   = 4;
    localparam int unsigned MAX_TIME = 9999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [TIME_W-1:0]   last_q;
    logic [TIME_W-1:0]   load_val_q;
    logic [TIME_W-1:0]   shreg_q;
    logic [TIME_W-1:0]   scratch_q;
    logic [ITER_W-1:0]   iter_q;
    logic [TIME_W-1:0]   bcd_q;

    logic [RW-1:0]       refresh_q;
    logic [1:0]          digit_q;
    logic [BW-1:0]       blink_cnt_q;
    logic                phase_on_q;

    logic [3:0]          an_q;
    logic [6:0]          seg_q;
    logic                dp_q;

    logic [TIME_W-1:0]   clamped_c;
    logic [TIME_W-1:0]   adj_c;
    logic [TIME_W-1:0]   disp_c;
    logic [3:0]          shown_c;
    logic [3:0]          nib_c;
    logic                blank_all_c;
    logic [3:0]          an_d;
    logic [6:0]          seg_d;

    // Active-low gfedcba pattern for one BCD digit; non-decimal nibbles are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Saturate the input at the largest 4-digit value.
    assign clamped_c = (bus.curr_time > TIME_W'(MAX_TIME)) ? TIME_W'(MAX_TIME) : bus.curr_time;

    // Double-dabble correction: add 3 to every scratch nibble that is 5 or more.
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < 4; i++) begin
            adj_c[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? (scratch_q[4*i +: 4] + 4'd3)
                                                          : scratch_q[4*i +: 4];
        end
    end

    // Conversion FSM. The bcd output updates atomically in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= 16'hFFFF;
            load_val_q <= '0;
            shreg_q    <= '0;
            scratch_q  <= '0;
            iter_q     <= '0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clamped_c != last_q) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    load_val_q <= clamped_c;
                    shreg_q    <= clamped_c;
                    scratch_q  <= '0;
                    iter_q     <= '0;
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    {scratch_q, shreg_q} <= {adj_c, shreg_q} << 1;
                    iter_q               <= iter_q + ITER_W'(1);
                    if (iter_q == ITER_W'(15)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_q   <= scratch_q;
                    last_q  <= load_val_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Digit scan and blink timebases. Both run free from reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_q   <= '0;
            digit_q     <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            if (refresh_q == RW'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                digit_q   <= digit_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_on_q  <= ~phase_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    // Choose the digits to show, the blanking and the selected digit's drive.
    always_comb begin
        disp_c      = bus.isZero ? 16'h0000 : bcd_q;
        blank_all_c = (bus.isZero | bus.below200) & ~phase_on_q;
`ifdef LEADING_ZERO_BLANK_EN
        shown_c[3] = (disp_c[15:12] != 4'd0);
        shown_c[2] = shown_c[3] | (disp_c[11:8] != 4'd0);
        shown_c[1] = shown_c[2] | (disp_c[7:4] != 4'd0);
        shown_c[0] = 1'b1;
`else
        shown_c = 4'b1111;
`endif
        case (digit_q)
            2'd0:    nib_c = disp_c[3:0];
            2'd1:    nib_c = disp_c[7:4];
            2'd2:    nib_c = disp_c[11:8];
            default: nib_c = disp_c[15:12];
        endcase
        an_d = 4'b1111;
        if (!blank_all_c && shown_c[digit_q]) begin
            an_d[digit_q] = 1'b0;
        end
        seg_d = seg_decode(nib_c);
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= 1'b1;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.bcd = bcd_q;

endmodule

// File: tb/tb_meter_display_driver.sv
// Directed bench for meter_display_driver with REFRESH_DIV=4 and BLINK_DIV=32.
module tb_meter_display_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    meter_display_driver_if bus();

    meter_display_driver #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Count clock edges since reset release.
    always @(posedge clk) if (rst_n) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Hold reset for 5 edges and check the reset state, then release it.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        repeat (5) tick();
        check({name, " rst an"}, 32'(bus.an), 32'h0000000F);
        check({name, " rst seg"}, 32'(bus.seg), 32'h0000007F);
        check({name, " rst bcd"}, 32'(bus.bcd), 32'h00000000);
        check({name, " rst dp"}, 32'(bus.dp), 32'h00000001);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // Check an and seg over a window of cycles.
    // After edge n the selected digit is ((n-1)/4)%4. The phase is on when ((n-1)/32) is even.
    task automatic check_window(input string name, input int from, input int to, input logic [15:0] b);
        logic [15:0] disp;
        logic [3:0]  shown;
        logic [3:0]  ea;
        logic [3:0]  nib;
        logic        on;
        logic        blank;
        int          d;
        while (cyc < to) begin
            tick();
            if (cyc >= from) begin
                d     = ((cyc - 1) / 4) % 4;
                on    = (((cyc - 1) / 32) % 2) == 0;
                disp  = bus.isZero ? 16'h0000 : b;
                blank = (bus.isZero || bus.below200) && !on;
`ifdef LEADING_ZERO_BLANK_EN
                shown[3] = disp[15:12] != 4'd0;
                shown[2] = shown[3] || (disp[11:8] != 4'd0);
                shown[1] = shown[2] || (disp[7:4] != 4'd0);
                shown[0] = 1'b1;
`else
                shown = 4'b1111;
`endif
                ea = 4'b1111;
                if (!blank && shown[d]) ea[d] = 1'b0;
                check($sformatf("%s an c%0d", name, cyc), 32'(bus.an), 32'(ea));
                if (ea != 4'b1111) begin
                    nib = 4'(disp >> (4 * d));
                    check($sformatf("%s seg c%0d", name, cyc), 32'(bus.seg), 32'(seg_of(nib)));
                end
                check($sformatf("%s dp c%0d", name, cyc), 32'(bus.dp), 32'h1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then the first conversion of 10 lands exactly 19 edges after release.
        bus.curr_time = 16'd10;
        bus.below200  = 1'b1;
        bus.isZero    = 1'b0;
        do_reset("t1");
        wait_until(18);
        check("t1 bcd@18", 32'(bus.bcd), 32'h0000);
        tick();
        check("t1 bcd@19", 32'(bus.bcd), 32'h0010);

        // 9999 shown steadily on all digits.
        bus.curr_time = 16'd9999;
        bus.below200  = 1'b0;
        do_reset("t2");
        wait_until(19);
        check("t2 bcd", 32'(bus.bcd), 32'h9999);
        check_window("t2", 21, 60, 16'h9999);

        // Out-of-range input saturates at 9999.
        bus.curr_time = 16'd12345;
        do_reset("t3");
        wait_until(18);
        check("t3 bcd@18", 32'(bus.bcd), 32'h0000);
        tick();
        check("t3 bcd@19", 32'(bus.bcd), 32'h9999);

        // A change during SHIFT is deferred until IDLE. After that, 199 blinks.
        bus.curr_time = 16'd205;
        bus.below200  = 1'b0;
        do_reset("t4");
        wait_until(7);
        bus.curr_time = 16'd199;
        bus.below200  = 1'b1;
        wait_until(19);
        check("t4 bcd@19", 32'(bus.bcd), 32'h0205);
        wait_until(37);
        check("t4 bcd@37", 32'(bus.bcd), 32'h0205);
        tick();
        check("t4 bcd@38", 32'(bus.bcd), 32'h0199);
        check_window("t4", 40, 140, 16'h0199);

        // isZero takes priority over below200 and shows zeros with blinking.
        bus.curr_time = 16'd1;
        bus.below200  = 1'b1;
        bus.isZero    = 1'b0;
        do_reset("t5");
        wait_until(19);
        check("t5 bcd", 32'(bus.bcd), 32'h0001);
        bus.isZero = 1'b1;
        check_window("t5", 22, 100, 16'h0001);
        bus.isZero = 1'b0;

        // Value 10 is steady. Leading digits depend on the blanking option.
        bus.curr_time = 16'd10;
        bus.below200  = 1'b0;
        do_reset("t6");
        wait_until(19);
        check("t6 bcd", 32'(bus.bcd), 32'h0010);
        check_window("t6", 21, 60, 16'h0010);
        wait_until(61);
        // Edge 61 scans digit ((61-1)/4)%4 = 3, the thousands digit.
`ifdef LEADING_ZERO_BLANK_EN
        check("t6 thousands", 32'(bus.an), 32'hF);
`else
        check("t6 thousands", 32'(bus.an), 32'h7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
